// File: rtl/mem_4_3_pkg.sv
// Shared constants for the two-requester memory arbiter: width defaults,
// FSM state encoding and the reset value of the round-robin pointer.
package mem_4_3_pkg;

  localparam int DW_DEF = 3;
  localparam int AW_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last-served pointer starts at requester 1 so requester 0 wins the first tie.
  localparam logic PTR_RST = 1'b1;

endpackage

// File: rtl/mem_4_3.sv
// Small asynchronous-read, synchronous-write memory used as the arbiter's
// target; data appears on o only while selected for a read with output enabled.
module mem_4_3
  import mem_4_3_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic [DW-1:0] i,
  input  logic [AW-1:0] a,
  input  logic          cs,
  input  logic          rd,
  input  logic          oe,
  output logic [DW-1:0] o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_r [DEPTH];

  // Write port: commits at the rising edge that ends a selected write cycle.
  always_ff @(posedge clk) begin
    if (cs && !rd) begin
      mem_r[a] <= i;
    end
  end

  assign o = (cs && rd && oe) ? mem_r[a] : {DW{1'b0}};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: ptr names the requester served last, which
// loses a tie; a lone request is granted regardless of the pointer.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1
);

  // One-hot grant selection.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (ptr) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

endmodule

// File: rtl/mem_4_3_arbiter.sv
// Arbitrates two requesters onto one memory port with a four-state
// IDLE/SETUP/ACCESS/DONE sequence; all outputs come straight from flops.
module mem_4_3_arbiter
  import mem_4_3_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [DW-1:0] mem_i,
  output logic [AW-1:0] mem_a,
  output logic          mem_cs,
  output logic          mem_rd,
  output logic          mem_oe,
  input  logic [DW-1:0] mem_o
);

  state_t        state_r, next_state_s;
  logic          arb_req0_s, arb_req1_s;
  logic          gnt0_s, gnt1_s, grant_s;
  logic          ptr_r, gid_r, we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r, rdata_r;
  logic          ack0_s, ack1_s, busy_s, cs_s, rd_s, oe_s;
  logic          ack0_r, ack1_r, busy_r, cs_r, rd_r, oe_r;

  // Requests are only looked at in IDLE, so a granted requester is ignored mid-transaction.
  assign arb_req0_s = req0 && (state_r == ST_IDLE);
  assign arb_req1_s = req1 && (state_r == ST_IDLE);

  rr_arb2 u_arb (
    .req0 (arb_req0_s),
    .req1 (arb_req1_s),
    .ptr  (ptr_r),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s)
  );

  assign grant_s = gnt0_s | gnt1_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:  next_state_s = ST_ACCESS;
      ST_ACCESS: next_state_s = ST_DONE;
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs, computed for the state being entered so the flops below line up with it.
  always_comb begin
    busy_s = 1'b0;
    cs_s   = 1'b0;
    rd_s   = 1'b0;
    oe_s   = 1'b0;
    ack0_s = 1'b0;
    ack1_s = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_SETUP: begin
        busy_s = 1'b1;
      end
      ST_ACCESS: begin
        busy_s = 1'b1;
        cs_s   = 1'b1;
        rd_s   = ~we_r;
        oe_s   = ~we_r;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        ack0_s = ~gid_r;
        ack1_s = gid_r;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      cs_r   <= 1'b0;
      rd_r   <= 1'b0;
      oe_r   <= 1'b0;
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      cs_r   <= cs_s;
      rd_r   <= rd_s;
      oe_r   <= oe_s;
      ack0_r <= ack0_s;
      ack1_r <= ack1_s;
    end
  end

  // Grant-time capture of the winner's command; held stable until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= PTR_RST;
      gid_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else if (grant_s) begin
      ptr_r   <= gnt1_s;
      gid_r   <= gnt1_s;
      we_r    <= gnt1_s ? we1 : we0;
      addr_r  <= gnt1_s ? addr1 : addr0;
      wdata_r <= gnt1_s ? wdata1 : wdata0;
    end else begin
      ptr_r   <= ptr_r;
      gid_r   <= gid_r;
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Read data is sampled at the end of ACCESS and otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if ((state_r == ST_ACCESS) && !we_r) begin
      rdata_r <= mem_o;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign ack0   = ack0_r;
  assign ack1   = ack1_r;
  assign busy   = busy_r;
  assign mem_cs = cs_r;
  assign mem_rd = rd_r;
  assign mem_oe = oe_r;
  assign mem_a  = addr_r;
  assign mem_i  = wdata_r;
  assign rdata  = rdata_r;

endmodule

// File: tb/tb_mem_4_3_arbiter.sv
// Scoreboard bench: a transaction-level model predicts ack order, ack cycle
// and rdata; a monitor pops the prediction on every ack and compares.
module tb_mem_4_3_arbiter;
  import mem_4_3_pkg::*;

  localparam int DW = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_cs, mem_rd, mem_oe;
  logic [DW-1:0] rdata, mem_i, mem_o;
  logic [AW-1:0] mem_a;

  mem_4_3_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_i(mem_i), .mem_a(mem_a), .mem_cs(mem_cs), .mem_rd(mem_rd),
    .mem_oe(mem_oe), .mem_o(mem_o)
  );

  mem_4_3 #(.DW(DW), .AW(AW)) u_mem (
    .clk(clk), .i(mem_i), .a(mem_a), .cs(mem_cs), .rd(mem_rd), .oe(mem_oe), .o(mem_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  typedef struct {
    int            who;
    int            at;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [4];
  int            last_m = 1;
  logic [DW-1:0] rd_m = '0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic txn_t tx(input bit we, input int a, input int d);
    txn_t t;
    t.we = we;
    t.a  = AW'(a);
    t.d  = DW'(d);
    return t;
  endfunction

  // Reference: apply one transaction to the model memory and predict its ack.
  task automatic model_txn(input int who, input int at, input txn_t t);
    exp_t e;
    if (t.we) mem_m[t.a] = t.d;
    else      rd_m = mem_m[t.a];
    e.who = who;
    e.at  = at;
    e.rd  = rd_m;
    exp_q.push_back(e);
    last_m = who;
  endtask

  // Monitor: every ack is matched against the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && (ack0 || ack1)) begin
      chk("ack_exclusive", int'(ack0 && ack1), 0);
      chk("busy_in_done", int'(busy), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none (cycle %0d)", ack0, ack1, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_who", ack1 ? 1 : 0, e.who);
        chk("ack_cycle", cyc, e.at);
        chk("rdata", int'(rdata), int'(e.rd));
      end
    end
  end

  // One arbitration round, started from IDLE at a falling edge.
  task automatic round(input bit r0, input bit r1, input txn_t t0, input txn_t t1, input bit early);
    int  c, first, second, n;
    bit  pend0, pend1;
    c = cyc;
    if (r0 && r1) begin
      first  = (last_m == 1) ? 0 : 1;
      second = 1 - first;
    end else begin
      first  = r1 ? 1 : 0;
      second = -1;
    end
    model_txn(first, c + 3, first ? t1 : t0);
    if (second >= 0) model_txn(second, c + 7, second ? t1 : t0);
    req0 = r0; we0 = t0.we; addr0 = t0.a; wdata0 = t0.d;
    req1 = r1; we1 = t1.we; addr1 = t1.a; wdata1 = t1.d;
    pend0 = r0;
    pend1 = r1;
    n = 0;
    while ((pend0 || pend1) && n < 12) begin
      @(negedge clk);
      n++;
      if (early && n == 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (ack0) begin req0 = 1'b0; pend0 = 1'b0; end
      if (ack1) begin req1 = 1'b0; pend1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: got pending req0=%0b req1=%0b, expected all acked", pend0, pend1);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack0"}, int'(ack0), 0);
    chk({tag, "_ack1"}, int'(ack1), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_mem_cs"}, int'(mem_cs), 0);
    chk({tag, "_mem_rd"}, int'(mem_rd), 0);
    chk({tag, "_mem_oe"}, int'(mem_oe), 0);
    chk({tag, "_mem_a"}, int'(mem_a), 0);
    chk({tag, "_mem_i"}, int'(mem_i), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   sweep_base, aw;
    txn_t idle_t;
    idle_t = tx(1'b0, 0, 0);

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep: rows written by alternating requesters, then read back.
    sweep_base = errors;
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) round(1'b1, 1'b0, tx(1'b1, r, 7 - r), idle_t, 1'b0);
      else            round(1'b0, 1'b1, idle_t, tx(1'b1, r, 7 - r), 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) round(1'b0, 1'b1, idle_t, tx(1'b0, r, 0), 1'b0);
      else            round(1'b1, 1'b0, tx(1'b0, r, 0), idle_t, 1'b0);
    end
    $display("Fail = %0d", errors - sweep_base);

    // Single write then read by requester 0.
    round(1'b1, 1'b0, tx(1'b1, 2, 5), idle_t, 1'b0);
    round(1'b1, 1'b0, tx(1'b0, 2, 0), idle_t, 1'b0);

    // Isolation: concurrent writes to different rows, then concurrent reads.
    round(1'b1, 1'b1, tx(1'b1, 3, 6), tx(1'b1, 0, 3), 1'b0);
    round(1'b1, 1'b1, tx(1'b0, 0, 0), tx(1'b0, 3, 0), 1'b0);
    round(1'b1, 1'b0, tx(1'b0, 3, 0), idle_t, 1'b0);

    // Request dropped in SETUP still completes and writes the row.
    round(1'b1, 1'b0, tx(1'b1, 1, 2), idle_t, 1'b1);
    round(1'b0, 1'b1, idle_t, tx(1'b0, 1, 0), 1'b0);

    // Reset during ACCESS: everything clears at once, the write is lost, no ack follows.
    aw = 1;
    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(aw); wdata0 = ~mem_m[aw];
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    req0 = 1'b0;
    last_m = 1;
    rd_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ties after reset: requester 0 first, then the next tie goes to requester 1.
    round(1'b1, 1'b1, tx(1'b0, 1, 0), tx(1'b0, 2, 0), 1'b0);
    round(1'b1, 1'b1, tx(1'b0, 3, 0), tx(1'b0, 0, 0), 1'b0);

    // Randomized rounds.
    for (int k = 0; k < 80; k++) begin
      int   mode;
      bit   early;
      txn_t a0, a1;
      mode  = $urandom_range(0, 2);
      a0    = tx(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7));
      a1    = tx(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7));
      early = (mode != 2) && ($urandom_range(0, 3) == 0);
      round(mode != 1, mode != 0, a0, a1, early);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
